// File: rtl/br_pkg.sv
// br_pkg: shared opcodes, counter states and decode helpers for the branch resolution unit.
package br_pkg;
   localparam logic [3:0] BR_EQ   = 4'd0;
   localparam logic [3:0] BR_NE   = 4'd1;
   localparam logic [3:0] BR_LT   = 4'd2;
   localparam logic [3:0] BR_GE   = 4'd3;
   localparam logic [3:0] BR_LTU  = 4'd4;
   localparam logic [3:0] BR_GEU  = 4'd5;
   localparam logic [3:0] BR_JAL  = 4'd6;
   localparam logic [3:0] BR_JALR = 4'd7;

   typedef logic [1:0] cnt_t;
   localparam cnt_t SNT = 2'd0;
   localparam cnt_t WNT = 2'd1;
   localparam cnt_t WT  = 2'd2;
   localparam cnt_t ST  = 2'd3;
   localparam cnt_t CNT_RST = WNT;

   // codes 8-15 are NONE
   function automatic logic is_none(input logic [3:0] op);
      return op[3];
   endfunction

   function automatic logic is_cond(input logic [3:0] op);
      return op < BR_JAL;
   endfunction
endpackage

// File: rtl/br_resolve_if.sv
// br_resolve_if: fetch-lookup, EX resolve and statistics signals of the branch unit.
interface br_resolve_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
   logic [XLEN-1:0]  if_pc;
   logic             if_pred_taken;
   logic             ex_valid;
   logic [3:0]       ex_bruop;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic [XLEN-1:0]  ex_imm;
   logic             ex_pred_taken;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             link_we;
   logic [XLEN-1:0]  link_data;
   logic             exc_misalign;
   logic [CNT_W-1:0] stat_branches;
   logic [CNT_W-1:0] stat_mispred;

   modport master (
      output if_pc, ex_valid, ex_bruop, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
      input  if_pred_taken, redirect_valid, redirect_pc, link_we, link_data, exc_misalign,
             stat_branches, stat_mispred
   );
   modport slave (
      input  if_pc, ex_valid, ex_bruop, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
      output if_pred_taken, redirect_valid, redirect_pc, link_we, link_data, exc_misalign,
             stat_branches, stat_mispred
   );
endinterface

// File: rtl/br_bht.sv
// br_bht: bimodal table of 2-bit saturating counters; read is combinational and
// sees the pre-update value when the same index is written in that cycle.
module br_bht import br_pkg::*; #(
   parameter int ENTRIES = 64,
   localparam int IW = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] rd_idx,
   output logic          rd_taken,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_idx,
   input  logic          wr_taken
);
   cnt_t cnt [ENTRIES];
   cnt_t cur;

   assign cur      = cnt[wr_idx];
   assign rd_taken = cnt[rd_idx][1];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RST;
      else if (wr_en)
         cnt[wr_idx] <= wr_taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
endmodule

// File: rtl/br_resolve.sv
// br_resolve: resolves RV32I control transfers in EX, issues registered redirects,
// trains the BHT and keeps branch/mispredict statistics.
module br_resolve import br_pkg::*; #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input logic       clk,
   input logic       rst_n,
   br_resolve_if.slave bus
);
   localparam int IW = $clog2(BHT_ENTRIES);

   logic            acc, cond, jal, jalr, eq, lt, ltu, cmp, taken, mis, redir, link;
   logic [XLEN-1:0] tgt, seq, jtgt;
   logic            unused_pc;

   // the instruction in EX during a redirect cycle is wrong-path
   always_comb begin
      acc   = bus.ex_valid && !is_none(bus.ex_bruop) && !bus.redirect_valid;
      cond  = is_cond(bus.ex_bruop);
      jal   = bus.ex_bruop == BR_JAL;
      jalr  = bus.ex_bruop == BR_JALR;
      eq    = bus.ex_rs1 == bus.ex_rs2;
      lt    = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
      ltu   = bus.ex_rs1 < bus.ex_rs2;
      cmp   = bus.ex_bruop == BR_EQ  ? eq  :
              bus.ex_bruop == BR_NE  ? !eq :
              bus.ex_bruop == BR_LT  ? lt  :
              bus.ex_bruop == BR_GE  ? !lt :
              bus.ex_bruop == BR_LTU ? ltu : !ltu;
      taken = cond ? cmp : 1'b1;
      seq   = bus.ex_pc + XLEN'(4);
      jtgt  = bus.ex_rs1 + bus.ex_imm;
      tgt   = jalr ? {jtgt[XLEN-1:1], 1'b0} : bus.ex_pc + bus.ex_imm;
      mis   = acc && taken && tgt[1];
      redir = acc && !mis && (taken != bus.ex_pred_taken || jalr);
      link  = acc && !mis && (jal || jalr);
   end

   assign unused_pc = ^{bus.if_pc[XLEN-1:IW+2], bus.if_pc[1:0]};

   br_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (bus.if_pc[IW+1:2]),
      .rd_taken(bus.if_pred_taken),
      .wr_en   (acc && cond),
      .wr_idx  (bus.ex_pc[IW+1:2]),
      .wr_taken(cmp)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.link_we        <= 1'b0;
         bus.link_data      <= '0;
         bus.exc_misalign   <= 1'b0;
         bus.stat_branches  <= '0;
         bus.stat_mispred   <= '0;
      end else begin
         bus.redirect_valid <= redir;
         bus.link_we        <= link;
         bus.exc_misalign   <= mis;
         if (acc) begin
            bus.redirect_pc <= taken ? tgt : seq;
            bus.link_data   <= seq;
         end
         bus.stat_branches  <= bus.stat_branches + CNT_W'(acc);
         bus.stat_mispred   <= bus.stat_mispred + CNT_W'(redir);
      end
endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: vector table, hand sequences and random traffic checked against
// a behavioural model of the branch unit.
module tb_br_resolve;
   import br_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   br_resolve_if #(.XLEN(32), .CNT_W(32)) b ();
   br_resolve #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

   int tests = 0;
   int fails = 0;

   int          mb [64];
   bit          e_redir, e_link, e_mis;
   logic [31:0] e_rpc, e_ldata;
   int unsigned e_br, e_mp;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] pc, rs1, rs2, imm;
      bit          pred;
      bit          redir;
      logic [31:0] rpc;
      bit          link;
      bit          mis;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic bit mpred(input logic [31:0] pc);
      return mb[pc[7:2]] >= 2;
   endfunction

   task automatic mreset();
      foreach (mb[i]) mb[i] = 1;
      e_redir = 0; e_link = 0; e_mis = 0;
      e_rpc = 0; e_ldata = 0; e_br = 0; e_mp = 0;
   endtask

   task automatic model(input bit v, input logic [3:0] op, input logic [31:0] pc, rs1, rs2, imm, input bit pred);
      bit acc, tk;
      logic [31:0] t;
      acc = v && op < 8 && !e_redir;
      t = (op == 7) ? ((rs1 + imm) & ~32'd1) : pc + imm;
      case (op)
         0: tk = rs1 == rs2;
         1: tk = rs1 != rs2;
         2: tk = $signed(rs1) < $signed(rs2);
         3: tk = $signed(rs1) >= $signed(rs2);
         4: tk = rs1 < rs2;
         5: tk = rs1 >= rs2;
         default: tk = 1;
      endcase
      e_mis   = acc && tk && t[1];
      e_redir = acc && !e_mis && (tk != pred || op == 7);
      e_link  = acc && !e_mis && (op == 6 || op == 7);
      if (acc) begin
         e_rpc = tk ? t : pc + 4;
         e_ldata = pc + 4;
         e_br++;
         if (op < 6) mb[pc[7:2]] = tk ? (mb[pc[7:2]] == 3 ? 3 : mb[pc[7:2]] + 1)
                                      : (mb[pc[7:2]] == 0 ? 0 : mb[pc[7:2]] - 1);
      end
      if (e_redir) e_mp++;
   endtask

   // called at a negedge; returns at the following negedge
   task automatic step(input bit v, input logic [3:0] op, input logic [31:0] pc, rs1, rs2, imm,
                       input bit pred, input logic [31:0] qpc);
      b.ex_valid = v; b.ex_bruop = op; b.ex_pc = pc; b.ex_rs1 = rs1; b.ex_rs2 = rs2;
      b.ex_imm = imm; b.ex_pred_taken = pred; b.if_pc = qpc;
      #1;
      chk("if_pred_pre_edge", b.if_pred_taken, mpred(qpc));
      model(v, op, pc, rs1, rs2, imm, pred);
      @(posedge clk); #1;
      chk("redirect_valid", b.redirect_valid, e_redir);
      chk("link_we", b.link_we, e_link);
      chk("exc_misalign", b.exc_misalign, e_mis);
      if (e_redir) chk("redirect_pc", b.redirect_pc, e_rpc);
      if (e_link) chk("link_data", b.link_data, e_ldata);
      chk("stat_branches", b.stat_branches, e_br);
      chk("stat_mispred", b.stat_mispred, e_mp);
      chk("if_pred_post_edge", b.if_pred_taken, mpred(qpc));
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 4'd8, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_redirect_valid"}, b.redirect_valid, 0);
      chk({n, "_redirect_pc"}, b.redirect_pc, 0);
      chk({n, "_link_we"}, b.link_we, 0);
      chk({n, "_link_data"}, b.link_data, 0);
      chk({n, "_exc_misalign"}, b.exc_misalign, 0);
      chk({n, "_stat_branches"}, b.stat_branches, 0);
      chk({n, "_stat_mispred"}, b.stat_mispred, 0);
   endtask

   initial begin
      bit tr_tk [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
      bit tr_pr [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
      logic [31:0] pool [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
      int unsigned br_before;

      b.ex_valid = 0; b.ex_bruop = 0; b.ex_pc = 0; b.ex_rs1 = 0; b.ex_rs2 = 0;
      b.ex_imm = 0; b.ex_pred_taken = 0; b.if_pc = 0;
      mreset();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      foreach (pool[i]) begin
         b.if_pc = pool[i] + 32'h40 * i; #1;
         chk("reset_if_pred", b.if_pred_taken, 0);
      end
      @(negedge clk);
      rst_n = 1;

      tbl.push_back('{BR_EQ,   32'h100, 5, 5, 32'h20, 0, 1, 32'h120, 0, 0});
      tbl.push_back('{BR_LT,   32'h200, 32'hFFFF_FFFF, 1, 32'h10, 0, 1, 32'h210, 0, 0});
      tbl.push_back('{BR_LTU,  32'h200, 32'hFFFF_FFFF, 1, 32'h10, 0, 0, 0, 0, 0});
      tbl.push_back('{BR_LTU,  32'h204, 0, 32'hFFFF_FFFF, 32'h8, 0, 1, 32'h20C, 0, 0});
      tbl.push_back('{BR_NE,   32'h300, 3, 3, 32'h40, 1, 1, 32'h304, 0, 0});
      tbl.push_back('{BR_GE,   32'h308, 32'hFFFF_FFFF, 1, 32'h40, 0, 0, 0, 0, 0});
      tbl.push_back('{BR_GEU,  32'h30C, 32'hFFFF_FFFF, 1, 32'h40, 1, 0, 0, 0, 0});
      tbl.push_back('{BR_GE,   32'h310, 7, 7, 32'h14, 0, 1, 32'h324, 0, 0});
      tbl.push_back('{BR_JAL,  32'h400, 0, 0, 32'h40, 1, 0, 0, 1, 0});
      tbl.push_back('{BR_JAL,  32'h404, 0, 0, 32'h40, 0, 1, 32'h444, 1, 0});
      tbl.push_back('{BR_JALR, 32'h500, 32'h205, 0, 0, 1, 1, 32'h204, 1, 0});
      tbl.push_back('{BR_JALR, 32'h504, 32'h203, 0, 0, 1, 0, 0, 0, 1});
      tbl.push_back('{BR_JAL,  32'h100, 0, 0, 32'h6, 1, 0, 0, 0, 1});
      tbl.push_back('{BR_EQ,   32'h600, 1, 1, 32'h2, 1, 0, 0, 0, 1});
      tbl.push_back('{BR_EQ,   32'hFFFF_FFF0, 1, 1, 32'h20, 0, 1, 32'h10, 0, 0});
      tbl.push_back('{BR_EQ,   32'h108, 1, 2, 32'h20, 1, 1, 32'h10C, 0, 0});
      tbl.push_back('{4'd8,    32'h100, 5, 5, 32'h20, 0, 0, 0, 0, 0});
      tbl.push_back('{4'd15,   32'h100, 5, 6, 32'h20, 1, 0, 0, 0, 0});
      foreach (tbl[i]) begin
         step(1, tbl[i].op, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].pred, tbl[i].pc);
         chk($sformatf("tbl%0d_redirect", i), b.redirect_valid, tbl[i].redir);
         if (tbl[i].redir) chk($sformatf("tbl%0d_redirect_pc", i), b.redirect_pc, tbl[i].rpc);
         chk($sformatf("tbl%0d_link_we", i), b.link_we, tbl[i].link);
         if (tbl[i].link) chk($sformatf("tbl%0d_link_data", i), b.link_data, tbl[i].pc + 4);
         chk($sformatf("tbl%0d_misalign", i), b.exc_misalign, tbl[i].mis);
         idle();
      end
      chk("tbl_stat_branches", b.stat_branches, 16);
      chk("tbl_stat_mispred", b.stat_mispred, 9);

      // BNE at 0x40: climb past saturation, fall to 0 and past it, climb back
      for (int i = 0; i < 11; i++) begin
         step(1, BR_NE, 32'h40, 1, tr_tk[i] ? 32'd2 : 32'd1, 32'h80, mpred(32'h40), 32'h40);
         chk($sformatf("train%0d_pred", i), b.if_pred_taken, tr_pr[i]);
         idle();
      end

      step(1, BR_EQ, 32'h700, 1, 1, 32'h10, 0, 32'h7C0);
      chk("squash_first_redirect", b.redirect_valid, 1);
      br_before = e_br;
      step(1, BR_EQ, 32'h7C0, 1, 1, 32'h10, 0, 32'h7C0);
      chk("squash_no_redirect", b.redirect_valid, 0);
      chk("squash_no_link", b.link_we, 0);
      chk("squash_branches", b.stat_branches, br_before);
      chk("squash_bht", b.if_pred_taken, 0);
      step(1, BR_EQ, 32'h7C0, 1, 1, 32'h10, 1, 32'h7C0);
      chk("after_squash_branches", b.stat_branches, br_before + 1);
      chk("after_squash_bht", b.if_pred_taken, 1);
      idle();

      step(1, BR_EQ, 32'h800, 1, 1, 32'h10, 0, 32'h40);
      chk("pre_reset_redirect", b.redirect_valid, 1);
      chk("pre_reset_bht", b.if_pred_taken, 1);
      #2 rst_n = 0;
      #1;
      chk_zero("midreset");
      chk("midreset_bht_40", b.if_pred_taken, 0);
      b.if_pc = 32'h7C0; #1;
      chk("midreset_bht_7c0", b.if_pred_taken, 0);
      mreset();
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 400; i++) begin
         logic [31:0] imm;
         imm = 32'($urandom_range(0, 63)) << 1;
         if ($urandom_range(0, 1) == 1) imm = -imm;
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 11)),
              32'($urandom_range(0, 255)) << 2,
              $urandom_range(0, 4) == 4 ? $urandom() : pool[$urandom_range(0, 3)],
              $urandom_range(0, 4) == 4 ? $urandom() : pool[$urandom_range(0, 3)],
              imm, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)) << 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
